// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter
// Round-robin sharing of one LS7212-style delay timer among N_REQ requesters.
// The winner's weight is placed on the timer wb bus, the timer runs one
// operate-delay cycle (trigger high until out_n falls, trigger low until out_n
// rises), and the requester gets a one-cycle done or err pulse. A watchdog
// pulses tmr_reset if the timer never answers.
module delay_timer_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WB_W    = 8,
  parameter int SETTLE  = 2,
  parameter int TIMEOUT = 1024,
  parameter int TO_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*WB_W-1:0] req_wb,
  output logic [N_REQ-1:0]      gnt,
  output logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      err,
  output logic                  busy,
  output logic [WB_W-1:0]       tmr_wb,
  output logic                  tmr_mode_a,
  output logic                  tmr_mode_b,
  output logic                  tmr_trigger,
  output logic                  tmr_reset,
  input  logic                  tmr_delay_out_n
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int ST_W  = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_TRIG    = 3'd2;
  localparam logic [2:0] S_RELEASE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ABORT   = 3'd5;
  localparam logic [2:0] S_REJECT  = 3'd6;

  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);
  localparam logic [ST_W-1:0]  SETTLE_LAST = ST_W'(SETTLE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_REQ - 1);

  logic [2:0]       state_q,  state_d;
  logic [IDX_W-1:0] ptr_q,    ptr_d;
  logic [IDX_W-1:0] w_q,      w_d;
  logic [N_REQ-1:0] gnt_q,    gnt_d;
  logic [N_REQ-1:0] done_q,   done_d;
  logic [N_REQ-1:0] err_q,    err_d;
  logic [WB_W-1:0]  tmr_wb_q, tmr_wb_d;
  logic             trig_q,   trig_d;
  logic [TO_W-1:0]  wdog_q,   wdog_d;
  logic [ST_W-1:0]  settle_q, settle_d;
  logic [1:0]       sync_q,   sync_d;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [WB_W-1:0]  win_wb;
  logic [IDX_W-1:0] scan_idx;
  logic             out_n_s;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [N_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign out_n_s     = sync_q[1];
  assign gnt         = gnt_q;
  assign done        = done_q;
  assign err         = err_q;
  assign busy        = (state_q != S_IDLE);
  assign tmr_wb      = tmr_wb_q;
  assign tmr_mode_a  = 1'b0;
  assign tmr_mode_b  = 1'b0;
  assign tmr_trigger = trig_q;
  // Timer is held in reset with the system and pulsed for one cycle on abort.
  assign tmr_reset   = reset | (state_q == S_ABORT);

  // Two-flop synchronizer for the asynchronous timer output.
  always_comb begin
    sync_d = {sync_q[0], tmr_delay_out_n};
  end

  // Round-robin scan starting at ptr; first set request wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_wb    = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = IDX_W'((int'(ptr_q) + k) % N_REQ);
      if (!win_found && req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
        win_wb    = req_wb[scan_idx*WB_W +: WB_W];
      end
    end
  end

  // Service FSM: next state plus the registered grant/pulse/trigger outputs.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    w_d      = w_q;
    gnt_d    = gnt_q;
    tmr_wb_d = tmr_wb_q;
    wdog_d   = wdog_q;
    settle_d = settle_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          w_d   = win_idx;
          gnt_d = onehot(win_idx);
          if (win_wb == '0) begin
            // Zero weight is refused without touching the timer bus.
            state_d = S_REJECT;
          end else begin
            state_d  = S_LOAD;
            tmr_wb_d = win_wb;
            settle_d = '0;
          end
        end
      end
      S_LOAD: begin
        // Hold wb/mode steady with trigger low so the timer sees stable inputs.
        if (settle_q == SETTLE_LAST) begin
          state_d = S_TRIG;
          wdog_d  = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      S_TRIG: begin
        // The expected edge takes priority over a watchdog expiry.
        if (!out_n_s) begin
          state_d = S_RELEASE;
          wdog_d  = '0;
        end else if (wdog_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_RELEASE: begin
        if (out_n_s) begin
          state_d = S_DONE;
        end else if (wdog_q == TO_LAST) begin
          state_d = S_ABORT;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      S_DONE, S_ABORT, S_REJECT: begin
        // Pointer moves past the one just served; IDLE gives a one-cycle gap.
        state_d = S_IDLE;
        gnt_d   = '0;
        wdog_d  = '0;
        ptr_d   = (w_q == IDX_LAST) ? '0 : w_q + 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        wdog_d  = '0;
      end
    endcase
    done_d = (state_d == S_DONE) ? onehot(w_d) : '0;
    err_d  = (state_d == S_REJECT || state_d == S_ABORT) ? onehot(w_d) : '0;
    trig_d = (state_d == S_TRIG);
  end

  // State registers; reset silently abandons any service in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ptr_q    <= '0;
      w_q      <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      err_q    <= '0;
      tmr_wb_q <= '0;
      trig_q   <= 1'b0;
      wdog_q   <= '0;
      settle_q <= '0;
      sync_q   <= 2'b11;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      w_q      <= w_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      err_q    <= err_d;
      tmr_wb_q <= tmr_wb_d;
      trig_q   <= trig_d;
      wdog_q   <= wdog_d;
      settle_q <= settle_d;
      sync_q   <= sync_d;
    end
  end

endmodule

// File: tb/tb_delay_timer_arbiter.sv
// Bench for delay_timer_arbiter with a behavioural LS7212 timer model:
// out_n falls wb clocks after trigger rises and rises one clock after release.
module tb_delay_timer_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_wb;
  logic [N-1:0]   gnt, done, err;
  logic           busy;
  logic [W-1:0]   tmr_wb;
  logic           tmr_mode_a, tmr_mode_b, tmr_trigger, tmr_reset;
  logic           model_out_n;

  int  n_chk  = 0;
  int  n_fail = 0;
  bit  stuck  = 1'b0;
  int  mcnt   = 0;

  always #500 clk = ~clk;

  delay_timer_arbiter #(.N_REQ(N), .WB_W(W), .SETTLE(2), .TIMEOUT(TO), .TO_W(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wb(req_wb),
    .gnt(gnt), .done(done), .err(err), .busy(busy),
    .tmr_wb(tmr_wb), .tmr_mode_a(tmr_mode_a), .tmr_mode_b(tmr_mode_b),
    .tmr_trigger(tmr_trigger), .tmr_reset(tmr_reset),
    .tmr_delay_out_n(model_out_n)
  );

  // Timer model
  always @(posedge clk) begin
    if (tmr_reset) begin
      model_out_n <= 1'b1;
      mcnt        <= 0;
    end else if (tmr_trigger) begin
      if (!stuck && model_out_n) begin
        if (mcnt + 1 >= int'(tmr_wb)) model_out_n <= 1'b0;
        mcnt <= mcnt + 1;
      end
    end else begin
      model_out_n <= 1'b1;
      mcnt        <= 0;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One service: apply request, check grant, wait for done/err, check the
  // pulse, the settle delay, tmr_reset behaviour and the idle gap after it.
  task automatic serve(input logic [N-1:0] r, input logic [N*W-1:0] wbs, input int ew,
                       input bit eerr, input bit etrig, output int ntrig);
    int  cyc;
    int  npre;
    bit  got;
    bit  trig_seen;
    logic [N-1:0] oh;
    logic [W-1:0] ewb;
    oh     = '0;
    oh[ew] = 1'b1;
    ewb    = wbs[ew*W +: W];
    req    = r;
    req_wb = wbs;
    cyc = 0;
    while (gnt == '0 && cyc < 8) begin
      @(negedge clk);
      cyc++;
    end
    chk("grant", 32'(gnt), 32'(oh));
    chk("busy at grant", 32'(busy), 32'd1);
    got = 0; trig_seen = 0; ntrig = 0; npre = -1; cyc = 0;
    while (!got && cyc < 200) begin
      if (tmr_trigger) begin
        if (!trig_seen) npre = cyc;
        trig_seen = 1'b1;
        ntrig++;
      end
      if ((done | err) != '0) got = 1'b1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("completion within bound", 32'(got), 32'd1);
    req = '0;
    chk("done pulse", 32'(done), eerr ? 32'd0 : 32'(oh));
    chk("err pulse", 32'(err), eerr ? 32'(oh) : 32'd0);
    chk("gnt at end", 32'(gnt), 32'(oh));
    chk("trigger seen", 32'(trig_seen), 32'(etrig));
    chk("tmr_reset at end", 32'(tmr_reset), 32'(eerr && etrig));
    if (etrig) begin
      chk("settle cycles", 32'(npre), 32'd2);
      chk("tmr_wb", 32'(tmr_wb), 32'(ewb));
    end
    @(negedge clk);
    chk("pulse width", 32'(done | err), 32'd0);
    chk("gap gnt", 32'(gnt), 32'd0);
    chk("gap busy", 32'(busy), 32'd0);
    chk("tmr_reset after", 32'(tmr_reset), 32'd0);
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] wbs;
    int             ew;
    bit             eerr;
    bit             etrig;
  } vec_t;

  vec_t tbl[11];

  initial begin
    int ntrig;
    int ndone;
    int cyc;
    bit prev_pulse;

    // {req, {wb3,wb2,wb1,wb0}, winner, err, trigger}
    tbl[0]  = '{4'b0001, {8'd0, 8'd0, 8'd0, 8'd10}, 0, 1'b0, 1'b1};
    tbl[1]  = '{4'b0010, {8'd0, 8'd0, 8'd3, 8'd0},  1, 1'b0, 1'b1};
    tbl[2]  = '{4'b0011, {8'd0, 8'd0, 8'd3, 8'd4},  0, 1'b0, 1'b1};  // ptr=2 wraps to 0
    tbl[3]  = '{4'b0100, {8'd0, 8'd0, 8'd0, 8'd0},  2, 1'b1, 1'b0};  // zero weight
    tbl[4]  = '{4'b1011, {8'd5, 8'd0, 8'd4, 8'd6},  3, 1'b0, 1'b1};  // ptr=3 after reject
    tbl[5]  = '{4'b1000, {8'd0, 8'd0, 8'd0, 8'd0},  3, 1'b1, 1'b0};
    tbl[6]  = '{4'b0110, {8'd0, 8'd7, 8'd2, 8'd0},  1, 1'b0, 1'b1};
    tbl[7]  = '{4'b0110, {8'd0, 8'd7, 8'd2, 8'd0},  2, 1'b0, 1'b1};
    tbl[8]  = '{4'b0011, {8'd0, 8'd0, 8'd3, 8'd2},  0, 1'b0, 1'b1};
    tbl[9]  = '{4'b0010, {8'd0, 8'd0, 8'd1, 8'd0},  1, 1'b0, 1'b1};  // minimum weight
    tbl[10] = '{4'b1111, {8'd9, 8'd9, 8'd9, 8'd0},  2, 1'b0, 1'b1};

    reset  = 1'b1;
    req    = '0;
    req_wb = '0;
    repeat (3) @(negedge clk);
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset tmr_wb", 32'(tmr_wb), 32'd0);
    chk("reset trigger", 32'(tmr_trigger), 32'd0);
    chk("reset tmr_reset", 32'(tmr_reset), 32'd1);
    chk("mode", 32'({tmr_mode_a, tmr_mode_b}), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("tmr_reset released", 32'(tmr_reset), 32'd0);

    // All four requesting with equal weight: 0,1,2,3 then 0 again.
    req    = 4'b1111;
    req_wb = {8'd3, 8'd3, 8'd3, 8'd3};
    ndone = 0; cyc = 0; prev_pulse = 1'b0;
    while (ndone < 5 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      chk("rr gnt onehot0", 32'($onehot0(gnt)), 32'd1);
      if (prev_pulse) begin
        chk("rr gap", 32'(gnt), 32'd0);
        prev_pulse = 1'b0;
      end
      if (done != '0) begin
        chk("rr order", 32'(done), 32'd1 << (ndone % 4));
        ndone++;
        prev_pulse = 1'b1;
        if (ndone == 5) req = '0;
      end
    end
    chk("rr count", 32'(ndone), 32'd5);
    @(negedge clk);
    chk("rr final gap", 32'(gnt), 32'd0);

    for (int i = 0; i < 11; i++)
      serve(tbl[i].req, tbl[i].wbs, tbl[i].ew, tbl[i].eerr, tbl[i].etrig, ntrig);

    // Stuck timer: watchdog aborts after TIMEOUT trigger cycles.
    stuck = 1'b1;
    serve(4'b0001, {8'd0, 8'd0, 8'd0, 8'd10}, 0, 1'b1, 1'b1, ntrig);
    chk("abort trigger cycles", 32'(ntrig), 32'(TO));
    stuck = 1'b0;

    // Reset in the middle of TRIG: silent abandon, then normal service.
    req    = 4'b0001;
    req_wb = {8'd0, 8'd0, 8'd0, 8'd10};
    cyc = 0;
    while (!tmr_trigger && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("trigger before reset", 32'(tmr_trigger), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset gnt", 32'(gnt), 32'd0);
    chk("midreset trigger", 32'(tmr_trigger), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset pulses", 32'(done | err), 32'd0);
    chk("midreset tmr_reset", 32'(tmr_reset), 32'd1);
    req   = '0;
    reset = 1'b0;
    @(negedge clk);
    chk("post reset pulses", 32'(done | err), 32'd0);
    chk("post reset busy", 32'(busy), 32'd0);
    serve(4'b0001, {8'd0, 8'd0, 8'd0, 8'd4}, 0, 1'b0, 1'b1, ntrig);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
